scan_sequencer: RTL

Generates the 3-bit channel index and enable that drive the team's 3-to-8 one-hot decoder. Steps through 8 channels at a programmable dwell per channel, skipping masked channels. Supports up, down and ping-pong order, and continuous or single-pass operation. Typical uses are strobing LED columns, keypad rows or mux selects.

---
 rtl/scan_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - channel index sequencer for a 3-to-8 one-hot decoder.
// Up/down/ping-pong scan over enabled channels with per-slot dwell and pass reporting.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic               single,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         chan_mask,
  output logic [2:0]         sel,
  output logic               sel_en,
  output logic               busy,
  output logic               slot_tick,
  output logic               pass_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  // {valid, index} of nearest enabled channel strictly above / below s
  function automatic logic [3:0] find_above(input logic [7:0] m, input logic [2:0] s);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--)
      if (i > int'(s) && m[i]) r = {1'b1, 3'(i)};
    return r;
  endfunction

  function automatic logic [3:0] find_below(input logic [7:0] m, input logic [2:0] s);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 8; i++)
      if (i < int'(s) && m[i]) r = {1'b1, 3'(i)};
    return r;
  endfunction

  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [2:0] highest(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  state_t             state, state_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               single_q, single_d;
  logic               dir, dir_d;       // 1 = moving down (ping-pong only)
  logic               last, last_d;     // current slot closes a pass
  logic [2:0]         sel_d;
  logic               sel_en_d, busy_d, tick_d, pd_d;

  logic [2:0] lo, hi;
  logic [3:0] abv, blw, blw_nxt;
  logic       load, go_idle;
  logic [1:0] md;
  logic [2:0] nxt;
  logic       nxt_dir, nxt_last;

  assign lo      = lowest(chan_mask);
  assign hi      = highest(chan_mask);
  assign abv     = find_above(chan_mask, sel);
  assign blw     = find_below(chan_mask, sel);
  assign blw_nxt = find_below(chan_mask, nxt);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    mode_d   = mode_q;
    single_d = single_q;
    dir_d    = dir;
    last_d   = last;
    sel_d    = sel;
    sel_en_d = sel_en;
    busy_d   = busy;
    tick_d   = 1'b0;
    pd_d     = 1'b0;
    load     = 1'b0;
    go_idle  = 1'b0;
    md       = (state == IDLE) ? mode : mode_q;
    nxt      = sel;

    case (state)
      IDLE: begin
        if (start && chan_mask != 8'd0) begin
          state_d  = SCAN;
          mode_d   = mode;
          single_d = single;
          load     = 1'b1;
          nxt      = (mode == 2'b01) ? hi : lo;
        end
      end
      default: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (cnt != '0) begin
          cnt_d  = cnt - DWELL_W'(1);
          tick_d = (cnt == DWELL_W'(1));
          pd_d   = (cnt == DWELL_W'(1)) && last;
        end else if (chan_mask == 8'd0 || (single_q && last)) begin
          go_idle = 1'b1;
        end else begin
          load = 1'b1;
          case (mode_q)
            2'b01:   nxt = blw[3] ? blw[2:0] : hi;
            2'b10: begin
              if (!dir) nxt = abv[3] ? abv[2:0] : (blw[3] ? blw[2:0] : lo);
              else      nxt = blw[3] ? blw[2:0] : (abv[3] ? abv[2:0] : lo);
            end
            default: nxt = abv[3] ? abv[2:0] : lo;
          endcase
        end
      end
    endcase

    // Endpoints force the turn-around so ping-pong never repeats them
    if (nxt == hi)      nxt_dir = 1'b1;
    else if (nxt == lo) nxt_dir = 1'b0;
    else                nxt_dir = (nxt < sel);

    case (md)
      2'b01:   nxt_last = (nxt == lo);
      2'b10:   nxt_last = (lo == hi) || (nxt_dir && blw_nxt[2:0] == lo);
      default: nxt_last = (nxt == hi);
    endcase

    if (load) begin
      sel_d    = nxt;
      sel_en_d = 1'b1;
      busy_d   = 1'b1;
      cnt_d    = dwell;
      dir_d    = nxt_dir;
      last_d   = nxt_last;
      tick_d   = (dwell == '0);
      pd_d     = (dwell == '0) && nxt_last;
    end

    if (go_idle) begin
      state_d  = IDLE;
      sel_d    = 3'd0;
      sel_en_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = '0;
      tick_d   = 1'b0;
      pd_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= 2'b00;
      single_q  <= 1'b0;
      dir       <= 1'b0;
      last      <= 1'b0;
      sel       <= 3'd0;
      sel_en    <= 1'b0;
      busy      <= 1'b0;
      slot_tick <= 1'b0;
      pass_done <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      mode_q    <= mode_d;
      single_q  <= single_d;
      dir       <= dir_d;
      last      <= last_d;
      sel       <= sel_d;
      sel_en    <= sel_en_d;
      busy      <= busy_d;
      slot_tick <= tick_d;
      pass_done <= pd_d;
    end
  end

endmodule
